kth_ss_apb_sequencer: RTL and testbench

APB3 master that turns a command stream into APB transactions aimed at the kth_ss slave window. The window covers instruction memory at 0x0105_3000, input buffer at 0x0105_3100, output buffer at 0x0105_3200 and control/status at 0x0105_3300. The block sits directly upstream of kth_ss and drives its PADDR/PSEL/PENABLE/PWRITE/PWDATA. It adds a hardware poll command so a host can wait on the ret/status register without spinning the bus itself. Every command returns exactly one response carrying read data and an error code.

---
 rtl/kth_ss_apb_sequencer.sv | 179 +++++++++++++++++
 tb/tb_kth_ss_apb_sequencer.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/kth_ss_apb_sequencer.sv
// APB3 master that turns a command stream into write/read/poll transfers.
// Ports: cmd_* request side, rsp_* response side, busy, APB3 master bus.
module kth_ss_apb_sequencer #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 16,
  parameter int POLL_GAP       = 4,
  parameter int POLL_MAX       = 1024
) (
  input  logic                  clk_in,
  input  logic                  reset_int,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [1:0]            cmd_op,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic [1:0]            rsp_err,
  output logic                  busy,
  output logic [ADDR_WIDTH-1:0] PADDR,
  output logic                  PWRITE,
  output logic [DATA_WIDTH-1:0] PWDATA,
  output logic                  PSEL,
  output logic                  PENABLE,
  input  logic [DATA_WIDTH-1:0] PRDATA,
  input  logic                  PREADY,
  input  logic                  PSLVERR
);

  typedef enum logic [2:0] {
    IDLE, SETUP, ACCESS, GAP, RESP
  } state_t;

  localparam logic [1:0] OP_WR   = 2'b00;
  localparam logic [1:0] OP_POLL = 2'b10;
  localparam logic [1:0] OP_ILL  = 2'b11;

  localparam logic [1:0] E_OK   = 2'b00;
  localparam logic [1:0] E_SLV  = 2'b01;
  localparam logic [1:0] E_TO   = 2'b10;
  localparam logic [1:0] E_POLL = 2'b11;

  localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int PW = $clog2(POLL_MAX + 1);
  localparam int GW = $clog2(POLL_GAP + 1);

  localparam logic [WW-1:0] WAIT_LAST = WW'(TIMEOUT_CYCLES - 1);
  localparam logic [PW-1:0] POLL_LAST = PW'(POLL_MAX - 1);
  localparam logic [GW-1:0] GAP_LAST  = GW'(POLL_GAP - 1);

  state_t                state;
  logic [1:0]            op_q;
  logic [DATA_WIDTH-1:0] mask_q;
  logic [WW-1:0]         wait_cnt;
  logic [PW-1:0]         poll_cnt;
  logic [GW-1:0]         gap_cnt;

  // Write completions report zero data; reads report the bus data.
  logic [DATA_WIDTH-1:0] done_data;
  logic                  poll_hit;

  always_comb begin
    done_data = PWRITE ? '0 : PRDATA;
    poll_hit  = (PRDATA & mask_q) != '0;
  end

  always_ff @(posedge clk_in) begin
    if (reset_int) begin
      state     <= IDLE;
      op_q      <= '0;
      mask_q    <= '0;
      wait_cnt  <= '0;
      poll_cnt  <= '0;
      gap_cnt   <= '0;
      cmd_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= '0;
      busy      <= 1'b0;
      PADDR     <= '0;
      PWRITE    <= 1'b0;
      PWDATA    <= '0;
      PSEL      <= 1'b0;
      PENABLE   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          cmd_ready <= 1'b1;
          if (cmd_valid && cmd_ready) begin
            cmd_ready <= 1'b0;
            busy      <= 1'b1;
            op_q      <= cmd_op;
            mask_q    <= cmd_wdata;
            PADDR     <= cmd_addr;
            PWDATA    <= cmd_wdata;
            PWRITE    <= (cmd_op == OP_WR);
            if (cmd_op == OP_ILL) begin
              state     <= RESP;
              rsp_valid <= 1'b1;
              rsp_err   <= E_SLV;
              rsp_rdata <= '0;
            end else begin
              state <= SETUP;
              PSEL  <= 1'b1;
            end
          end
        end
        SETUP: begin
          PENABLE <= 1'b1;
          state   <= ACCESS;
        end
        ACCESS: begin
          if (PREADY) begin
            PSEL     <= 1'b0;
            PENABLE  <= 1'b0;
            wait_cnt <= '0;
            if (PSLVERR) begin
              state     <= RESP;
              rsp_valid <= 1'b1;
              rsp_err   <= E_SLV;
              rsp_rdata <= done_data;
            end else if (op_q != OP_POLL) begin
              state     <= RESP;
              rsp_valid <= 1'b1;
              rsp_err   <= E_OK;
              rsp_rdata <= done_data;
            end else if (poll_hit) begin
              state     <= RESP;
              rsp_valid <= 1'b1;
              rsp_err   <= E_OK;
              rsp_rdata <= PRDATA;
            end else if (poll_cnt == POLL_LAST) begin
              state     <= RESP;
              rsp_valid <= 1'b1;
              rsp_err   <= E_POLL;
              rsp_rdata <= PRDATA;
            end else begin
              poll_cnt <= poll_cnt + 1'b1;
              gap_cnt  <= '0;
              state    <= GAP;
            end
          end else if (wait_cnt == WAIT_LAST) begin
            // Stalled too long: abandon the transfer.
            PSEL      <= 1'b0;
            PENABLE   <= 1'b0;
            state     <= RESP;
            rsp_valid <= 1'b1;
            rsp_err   <= E_TO;
            rsp_rdata <= '0;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        GAP: begin
          if (gap_cnt == GAP_LAST) begin
            PSEL  <= 1'b1;
            state <= SETUP;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            busy      <= 1'b0;
            cmd_ready <= 1'b1;
            poll_cnt  <= '0;
            wait_cnt  <= '0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_kth_ss_apb_sequencer.sv
// Directed bench for kth_ss_apb_sequencer.
// Vector table plus reset sequences against a scripted APB slave.
module tb_kth_ss_apb_sequencer;

  logic        clk_in = 1'b0;
  logic        reset_int = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_op = '0;
  logic [31:0] cmd_addr = '0;
  logic [31:0] cmd_wdata = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_err;
  logic        busy;
  logic [31:0] PADDR;
  logic        PWRITE;
  logic [31:0] PWDATA;
  logic        PSEL;
  logic        PENABLE;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        PSLVERR;

  kth_ss_apb_sequencer #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32),
    .TIMEOUT_CYCLES(16), .POLL_GAP(4), .POLL_MAX(4)
  ) dut (
    .clk_in(clk_in), .reset_int(reset_int),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .busy(busy),
    .PADDR(PADDR), .PWRITE(PWRITE), .PWDATA(PWDATA),
    .PSEL(PSEL), .PENABLE(PENABLE),
    .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  always #5 clk_in = ~clk_in;

  // Scripted slave configuration.
  int          cfg_wait = 0;
  logic [31:0] cfg_rdata = '0;
  int          cfg_zero = 0;
  logic        cfg_err = 1'b0;
  logic        slv_clr = 1'b0;

  int          acc = 0;
  int          nreads = 0;
  int          nsetup = 0;
  logic [31:0] seen_addr = '0;
  logic [31:0] seen_wd = '0;
  logic        seen_wr = 1'b0;
  logic        unstable = 1'b0;
  logic        prot_bad = 1'b0;
  logic        psel_prev = 1'b0;

  assign PREADY  = PSEL && PENABLE && (acc >= cfg_wait);
  assign PSLVERR = PREADY && cfg_err;
  assign PRDATA  = PWRITE ? 32'h0 :
                   (nreads < cfg_zero ? 32'h0 : cfg_rdata);

  always @(posedge clk_in) begin
    if (slv_clr) begin
      acc    <= 0;
      nreads <= 0;
      nsetup <= 0;
    end else begin
      if (PSEL && !PENABLE) begin
        nsetup    <= nsetup + 1;
        seen_addr <= PADDR;
        seen_wd   <= PWDATA;
        seen_wr   <= PWRITE;
      end
      if (PSEL && PENABLE) begin
        if (PADDR != seen_addr || PWDATA != seen_wd || PWRITE != seen_wr)
          unstable <= 1'b1;
        if (PREADY) begin
          acc <= 0;
          if (!PWRITE) nreads <= nreads + 1;
        end else begin
          acc <= acc + 1;
        end
      end
    end
    if (PENABLE && !psel_prev) prot_bad <= 1'b1;
    psel_prev <= PSEL;
  end

  typedef struct {
    logic [1:0]  op;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          s_wait;
    logic [31:0] s_rdata;
    int          s_zero;
    logic        s_err;
    int          hold;
    logic [1:0]  e_err;
    logic [31:0] e_rdata;
    int          e_lat;
    int          e_setups;
    int          e_reads;
  } vec_t;

  vec_t vt[12];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic run(input vec_t v, input int idx);
    int t;
    cfg_wait  = v.s_wait;
    cfg_rdata = v.s_rdata;
    cfg_zero  = v.s_zero;
    cfg_err   = v.s_err;
    slv_clr   = 1'b1;
    @(posedge clk_in); #1;
    slv_clr   = 1'b0;
    cmd_op    = v.op;
    cmd_addr  = v.addr;
    cmd_wdata = v.wdata;
    cmd_valid = 1'b1;
    t = 0;
    while (!cmd_ready && t < 50) begin
      @(posedge clk_in); #1;
      t++;
    end
    if (!cmd_ready) begin
      checks++;
      errors++;
      $display("FAIL v%0d cmd_ready_wait actual=0 required=1", idx);
    end
    @(posedge clk_in); #1;
    cmd_valid = 1'b0;
    t = 1;
    if (v.e_setups > 0) begin
      chk($sformatf("v%0d setup_psel", idx), {31'b0, PSEL}, 32'd1);
      chk($sformatf("v%0d setup_pen", idx), {31'b0, PENABLE}, 32'd0);
    end
    while (!rsp_valid && t < 300) begin
      @(posedge clk_in); #1;
      t++;
    end
    chk($sformatf("v%0d latency", idx), t, v.e_lat);
    chk($sformatf("v%0d err", idx), {30'b0, rsp_err}, {30'b0, v.e_err});
    chk($sformatf("v%0d rdata", idx), rsp_rdata, v.e_rdata);
    chk($sformatf("v%0d psel_off", idx), {31'b0, PSEL}, 32'd0);
    chk($sformatf("v%0d setups", idx), nsetup, v.e_setups);
    chk($sformatf("v%0d reads", idx), nreads, v.e_reads);
    if (v.e_setups > 0)
      chk($sformatf("v%0d paddr", idx), seen_addr, v.addr);
    for (int h = 0; h < v.hold; h++) begin
      @(posedge clk_in); #1;
      chk($sformatf("v%0d hold_valid", idx), {31'b0, rsp_valid}, 32'd1);
      chk($sformatf("v%0d hold_cmdrdy", idx), {31'b0, cmd_ready}, 32'd0);
      chk($sformatf("v%0d hold_rdata", idx), rsp_rdata, v.e_rdata);
      chk($sformatf("v%0d hold_err", idx), {30'b0, rsp_err},
          {30'b0, v.e_err});
    end
    rsp_ready = 1'b1;
    @(posedge clk_in); #1;
    rsp_ready = 1'b0;
    chk($sformatf("v%0d rsp_done", idx), {31'b0, rsp_valid}, 32'd0);
    chk($sformatf("v%0d cmd_back", idx), {31'b0, cmd_ready}, 32'd1);
    chk($sformatf("v%0d busy_off", idx), {31'b0, busy}, 32'd0);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_psel"}, {31'b0, PSEL}, 32'd0);
    chk({tag, "_pen"}, {31'b0, PENABLE}, 32'd0);
    chk({tag, "_rspv"}, {31'b0, rsp_valid}, 32'd0);
    chk({tag, "_cmdrdy"}, {31'b0, cmd_ready}, 32'd0);
    chk({tag, "_busy"}, {31'b0, busy}, 32'd0);
    chk({tag, "_paddr"}, PADDR, 32'd0);
    chk({tag, "_pwdata"}, PWDATA, 32'd0);
    chk({tag, "_pwrite"}, {31'b0, PWRITE}, 32'd0);
    chk({tag, "_rdata"}, rsp_rdata, 32'd0);
    chk({tag, "_err"}, {30'b0, rsp_err}, 32'd0);
  endtask

  initial begin
    // op addr wdata wait rdata zero err hold | err rdata lat setups reads
    vt[0]  = '{2'b00, 32'h0105_3304, 32'h1, 0, 32'h0, 0, 1'b0, 0,
               2'b00, 32'h0, 3, 1, 0};
    vt[1]  = '{2'b01, 32'h0105_3200, 32'h0, 3, 32'hDEAD_BEEF, 0, 1'b0, 0,
               2'b00, 32'hDEAD_BEEF, 6, 1, 1};
    vt[2]  = '{2'b10, 32'h0105_3308, 32'h1, 0, 32'h1, 3, 1'b0, 0,
               2'b00, 32'h1, 21, 4, 4};
    vt[3]  = '{2'b10, 32'h0105_3308, 32'h1, 0, 32'h1, 100, 1'b0, 0,
               2'b11, 32'h0, 21, 4, 4};
    vt[4]  = '{2'b10, 32'h0105_3308, 32'h0, 0, 32'hFFFF_FFFF, 0, 1'b0, 0,
               2'b11, 32'hFFFF_FFFF, 21, 4, 4};
    vt[5]  = '{2'b01, 32'h0105_3100, 32'h0, 1000, 32'h5, 0, 1'b0, 0,
               2'b10, 32'h0, 18, 1, 0};
    vt[6]  = '{2'b00, 32'h0105_3000, 32'hA5A5_0001, 0, 32'h0, 0, 1'b1, 0,
               2'b01, 32'h0, 3, 1, 0};
    vt[7]  = '{2'b11, 32'h0105_3300, 32'h0, 0, 32'h0, 0, 1'b0, 0,
               2'b01, 32'h0, 1, 0, 0};
    vt[8]  = '{2'b01, 32'h0105_3204, 32'h0, 1, 32'h1234, 0, 1'b1, 0,
               2'b01, 32'h1234, 4, 1, 1};
    vt[9]  = '{2'b10, 32'h0105_330C, 32'h80, 2, 32'h80, 0, 1'b0, 0,
               2'b00, 32'h80, 5, 1, 1};
    vt[10] = '{2'b10, 32'h0105_3308, 32'h2, 0, 32'h5, 0, 1'b1, 0,
               2'b01, 32'h5, 3, 1, 1};
    vt[11] = '{2'b01, 32'h0105_3208, 32'h0, 0, 32'h7777_0000, 0, 1'b0, 5,
               2'b00, 32'h7777_0000, 3, 1, 1};

    repeat (3) @(posedge clk_in);
    #1;
    chk_zero("reset");
    reset_int = 1'b0;
    @(posedge clk_in); #1;
    chk("post_reset_cmdrdy", {31'b0, cmd_ready}, 32'd1);

    for (int i = 0; i < 12; i++) run(vt[i], i);

    // Reset while a read is stalled in ACCESS.
    cfg_wait  = 1000;
    slv_clr   = 1'b1;
    @(posedge clk_in); #1;
    slv_clr   = 1'b0;
    cmd_op    = 2'b01;
    cmd_addr  = 32'h0105_3200;
    cmd_valid = 1'b1;
    @(posedge clk_in); #1;
    cmd_valid = 1'b0;
    @(posedge clk_in); #1;
    chk("mid_access_pen", {31'b0, PENABLE}, 32'd1);
    @(posedge clk_in); #1;
    reset_int = 1'b1;
    @(posedge clk_in); #1;
    reset_int = 1'b0;
    chk_zero("midrst");
    @(posedge clk_in); #1;
    chk("midrst_cmdrdy", {31'b0, cmd_ready}, 32'd1);
    run(vt[0], 100);
    run(vt[1], 101);

    chk("paddr_pwdata_stable", {31'b0, unstable}, 32'd0);
    chk("penable_after_psel", {31'b0, prot_bad}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
